// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the writeback beat type (rd + data)
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_beat_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback bus; master drives alu/lsu/iss/query inputs, slave (arbiter) drives lsu_ready, busy_rs1/2, we3/A3/WD3
interface wb_arbiter_if import wb_pkg::*; #(parameter int XLEN = XLEN_DEF);
  logic alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic lsu_valid;
  logic lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [REG_AW-1:0] q_rs1;
  logic [REG_AW-1:0] q_rs2;
  logic busy_rs1;
  logic busy_rs2;
  logic we3;
  logic [REG_AW-1:0] A3;
  logic [XLEN-1:0] WD3;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, q_rs1, q_rs2,
    input lsu_ready, busy_rs1, busy_rs2, we3, A3, WD3
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, iss_valid, iss_rd, q_rs1, q_rs2,
    output lsu_ready, busy_rs1, busy_rs2, we3, A3, WD3
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: sync FIFO of beats; ports clk, rst_n (sync active-low), push/din, pop/dout, full, empty
module wb_fifo import wb_pkg::*; #(
  parameter type T = wb_beat_t,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU-priority writeback arbiter with LSU FIFO and pending scoreboard; ports clk, rst_n, bus (wb_arbiter_if.slave)
module wb_arbiter import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  wb_arbiter_if.slave bus
);
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0] data;
  } beat_t;
  logic ready, full, empty, alu_win, lsu_live, fall, pop, push, win_v, wb_from_lsu;
  beat_t head, lsu_beat, win;
  logic [31:0] pending, set, clr;
  assign ready = !full && rst_n;
  assign bus.lsu_ready = ready;
  assign alu_win = bus.alu_valid && bus.alu_rd != '0;
  assign lsu_live = bus.lsu_valid && ready && bus.lsu_rd != '0;
  assign fall = lsu_live && empty && !alu_win;
  assign pop = !empty && !alu_win;
  assign push = lsu_live && !fall;
  assign lsu_beat = '{rd: bus.lsu_rd, data: bus.lsu_data};
  assign win_v = alu_win || pop || fall;
  assign win = alu_win ? beat_t'{rd: bus.alu_rd, data: bus.alu_data} : pop ? head : lsu_beat;
  wb_fifo #(.T(beat_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(lsu_beat),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      bus.we3 <= 1'b0;
      bus.A3 <= '0;
      bus.WD3 <= '0;
      wb_from_lsu <= 1'b0;
    end else begin
      bus.we3 <= win_v;
      wb_from_lsu <= win_v && !alu_win;
      bus.A3 <= win_v ? win.rd : bus.A3;
      bus.WD3 <= win_v ? win.data : bus.WD3;
    end
  assign clr = (bus.we3 && wb_from_lsu) ? 32'(1) << bus.A3 : '0;
  assign set = (bus.iss_valid && bus.iss_rd != '0) ? 32'(1) << bus.iss_rd : '0;
  always_ff @(posedge clk)
    if (!rst_n) pending <= '0;
    else pending <= (pending & ~clr) | set;
  assign bus.busy_rs1 = bus.q_rs1 != '0 && pending[bus.q_rs1];
  assign bus.busy_rs2 = bus.q_rs2 != '0 && pending[bus.q_rs2];
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  wb_arbiter_if #(.XLEN(32)) bus ();
  wb_arbiter #(.XLEN(32), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string tag);
    chk({tag, "_we3"}, bus.we3, 1);
    chk({tag, "_a3"}, bus.A3, a);
    chk({tag, "_wd3"}, bus.WD3, d);
  endtask
  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd = rd;
    bus.alu_data = d;
  endtask
  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd = rd;
    bus.lsu_data = d;
  endtask
  task automatic iss(input logic v, input logic [4:0] rd);
    bus.iss_valid = v;
    bus.iss_rd = rd;
  endtask
  initial begin
    alu(0, 0, 0);
    lsu(0, 0, 0);
    iss(0, 0);
    bus.q_rs1 = 0;
    bus.q_rs2 = 0;
    step();
    step();
    chk("rst_we3", bus.we3, 0);
    chk("rst_a3", bus.A3, 0);
    chk("rst_wd3", bus.WD3, 0);
    chk("rst_ready", bus.lsu_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", bus.lsu_ready, 1);
    alu(1, 5, 32'hDEADBEEF);
    step();
    wr(5, 32'hDEADBEEF, "alu");
    alu(1, 0, 32'h1);
    step();
    chk("alu0_we3", bus.we3, 0);
    chk("alu0_a3_hold", bus.A3, 5);
    chk("alu0_wd3_hold", bus.WD3, 32'hDEADBEEF);
    alu(0, 0, 0);
    lsu(1, 7, 32'h1234);
    #1;
    chk("ft_ready", bus.lsu_ready, 1);
    step();
    wr(7, 32'h1234, "ft");
    alu(1, 1, 32'h11);
    lsu(1, 10, 32'hA0);
    #1;
    chk("bp_ready0", bus.lsu_ready, 1);
    step();
    wr(1, 32'h11, "bp_alu1");
    alu(1, 2, 32'h22);
    lsu(1, 11, 32'hB0);
    #1;
    chk("bp_ready1", bus.lsu_ready, 1);
    step();
    wr(2, 32'h22, "bp_alu2");
    alu(1, 3, 32'h33);
    lsu(1, 12, 32'hC0);
    #1;
    chk("bp_ready_full", bus.lsu_ready, 0);
    step();
    wr(3, 32'h33, "bp_alu3");
    alu(0, 0, 0);
    #1;
    chk("bp_still_full", bus.lsu_ready, 0);
    step();
    wr(10, 32'hA0, "bp_q0");
    chk("bp_ready_again", bus.lsu_ready, 1);
    step();
    wr(11, 32'hB0, "bp_q1");
    lsu(0, 0, 0);
    step();
    wr(12, 32'hC0, "bp_q2");
    step();
    chk("bp_idle_we3", bus.we3, 0);
    alu(1, 3, 32'hA);
    lsu(1, 4, 32'hB);
    #1;
    chk("col_ready", bus.lsu_ready, 1);
    step();
    wr(3, 32'hA, "col_alu");
    alu(0, 0, 0);
    lsu(0, 0, 0);
    #1;
    chk("col_ready_after", bus.lsu_ready, 1);
    step();
    wr(4, 32'hB, "col_lsu");
    step();
    chk("col_idle", bus.we3, 0);
    bus.q_rs1 = 9;
    bus.q_rs2 = 9;
    iss(1, 9);
    #1;
    chk("sb_pre", bus.busy_rs1, 0);
    step();
    iss(0, 0);
    chk("sb_set1", bus.busy_rs1, 1);
    chk("sb_set2", bus.busy_rs2, 1);
    alu(1, 9, 32'h90);
    step();
    alu(0, 0, 0);
    wr(9, 32'h90, "sb_alu");
    step();
    chk("sb_alu_keeps", bus.busy_rs1, 1);
    lsu(1, 9, 32'h99);
    step();
    lsu(0, 0, 0);
    wr(9, 32'h99, "sb_lsu");
    chk("sb_busy_at_we3", bus.busy_rs1, 1);
    step();
    chk("sb_cleared", bus.busy_rs1, 0);
    iss(1, 9);
    step();
    iss(0, 0);
    chk("sb_reset9", bus.busy_rs1, 1);
    lsu(1, 9, 32'h98);
    step();
    lsu(0, 0, 0);
    iss(1, 9);
    step();
    iss(0, 0);
    chk("sb_set_wins", bus.busy_rs1, 1);
    step();
    chk("sb_set_wins2", bus.busy_rs1, 1);
    lsu(1, 9, 32'h97);
    step();
    lsu(0, 0, 0);
    step();
    chk("sb_clear2", bus.busy_rs1, 0);
    bus.q_rs1 = 0;
    bus.q_rs2 = 0;
    iss(1, 0);
    step();
    iss(0, 0);
    chk("sb_rd0_1", bus.busy_rs1, 0);
    chk("sb_rd0_2", bus.busy_rs2, 0);
    bus.q_rs1 = 20;
    bus.q_rs2 = 21;
    iss(1, 20);
    step();
    iss(1, 21);
    step();
    iss(0, 0);
    chk("mr_busy1", bus.busy_rs1, 1);
    chk("mr_busy2", bus.busy_rs2, 1);
    alu(1, 2, 32'h2);
    lsu(1, 20, 32'h200);
    step();
    lsu(1, 21, 32'h210);
    step();
    alu(0, 0, 0);
    lsu(0, 0, 0);
    chk("mr_full", bus.lsu_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_ready_low", bus.lsu_ready, 0);
    step();
    chk("mr_we3", bus.we3, 0);
    chk("mr_a3", bus.A3, 0);
    chk("mr_wd3", bus.WD3, 0);
    chk("mr_b1", bus.busy_rs1, 0);
    chk("mr_b2", bus.busy_rs2, 0);
    chk("mr_ready_rst", bus.lsu_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mr_ready_rel", bus.lsu_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_stale", bus.we3, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
